// File: rtl/fp_exp_pkg.sv
// fp_exp_pkg: shared exponent-path constants and types.
// Used by the exponent adjust unit and the result packer.
package fp_exp_pkg;

  localparam int EXP_W_DEF   = 8;
  localparam int SHAMT_W_DEF = 5;

  typedef enum logic [1:0] {
    EXP_NORMAL  = 2'd0,
    EXP_OVF     = 2'd1,
    EXP_UDF     = 2'd2,
    EXP_SPECIAL = 2'd3
  } exp_status_e;

  function automatic int emax(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/fp_pipe_stage.sv
// fp_pipe_stage: valid/ready register slice.
// Loads when empty or when downstream takes the held beat.
module fp_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic load;

  assign load     = !out_valid || out_ready;
  assign in_ready = load;

  // hold the beat until downstream accepts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/fp_exponent_adjust.sv
// fp_exponent_adjust: two-stage exponent adjust with
// overflow saturation, flush-to-zero and sticky flags.
module fp_exponent_adjust
  import fp_exp_pkg::*;
#(
  parameter int EXP_W   = EXP_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [EXP_W-1:0]   exp_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               dir_right,
  input  logic               round_inc,
  input  logic               zero_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EXP_W-1:0]   exp_out,
  output logic               ovf,
  output logic               udf,
  output logic               ovf_sticky,
  output logic               udf_sticky,
  input  logic               clr_flags
);

  localparam int IW = EXP_W + 2;
  localparam logic [IW-1:0] EMAX_X =
    IW'(emax(EXP_W));
  localparam logic [EXP_W-1:0] EMAX_E =
    EXP_W'(emax(EXP_W));

  typedef struct packed {
    logic [IW-1:0] t;
    logic          rnd;
    logic          zero;
    logic          special;
  } s1_t;

  typedef struct packed {
    logic [EXP_W-1:0] e;
    logic             o;
    logic             u;
  } s2_t;

  s1_t         s1_d, s1_q;
  s2_t         s2_d, s2_q;
  logic        s1_valid;
  logic        s2_rdy;
  logic [IW-1:0] exp_x, sh_x, r;
  exp_status_e st;

  assign exp_x = IW'(exp_in);
  assign sh_x  = IW'(shamt);

  // stage 1: apply the normalisation shift
  always_comb begin
    s1_d         = '0;
    s1_d.t       = dir_right ? exp_x + sh_x
                             : exp_x - sh_x;
    s1_d.rnd     = round_inc;
    s1_d.zero    = zero_in;
    s1_d.special = (exp_in == EMAX_E);
  end

  fp_pipe_stage #(.W($bits(s1_t))) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_d),
    .out_valid (s1_valid),
    .out_ready (s2_rdy),
    .out_data  (s1_q)
  );

  // stage 2: rounding carry, then classify the result
  always_comb begin
    r  = s1_q.t + IW'(s1_q.rnd);
    st = EXP_NORMAL;
    if (s1_q.zero)                        st = EXP_UDF;
    else if (s1_q.special)                st = EXP_SPECIAL;
    else if ($signed(r) >= $signed(EMAX_X)) st = EXP_OVF;
    else if ($signed(r) <= 0)             st = EXP_UDF;
    s2_d   = '0;
    unique case (st)
      EXP_SPECIAL: s2_d.e = EMAX_E;
      EXP_OVF: begin
        s2_d.e = EMAX_E;
        s2_d.o = 1'b1;
      end
      EXP_UDF: begin
        s2_d.e = '0;
        s2_d.u = !s1_q.zero;
      end
      default: s2_d.e = r[EXP_W-1:0];
    endcase
  end

  fp_pipe_stage #(.W($bits(s2_t))) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_rdy),
    .in_data   (s2_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_q)
  );

  assign exp_out = s2_q.e;
  assign ovf     = s2_q.o;
  assign udf     = s2_q.u;

  logic xfer;
  assign xfer = out_valid && out_ready;

  // sticky flags: a flagged transfer beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else begin
      if (xfer && ovf)    ovf_sticky <= 1'b1;
      else if (clr_flags) ovf_sticky <= 1'b0;
      if (xfer && udf)    udf_sticky <= 1'b1;
      else if (clr_flags) udf_sticky <= 1'b0;
    end
  end

endmodule
